// File: rtl/vga_pixel_prefetch.sv
// Prefetches frame pixels from memory into a credit-limited FIFO and pops one per read_mem.
// Optional feature macro: PIX_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module vga_pixel_prefetch #(
  parameter int DEPTH     = 16,
  parameter int FRAME_PIX = 307200,
  parameter int AW        = 19
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vsync,
  input  logic                     read_mem,
  output logic [11:0]              pix_data,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic                     mem_rvalid,
  input  logic [11:0]              mem_rdata,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef PIX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              underflow_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = LW + 1;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [11:0]   fifo_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r, level_s, outstanding_r, outstanding_s, drop_cnt_s;
  logic [CW-1:0] credit_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic          mem_req_r, mem_req_s;
  logic [11:0]   pix_data_r;
  logic          underflow_r;
  logic          flush_s, accept_s, last_acc_s, rsp_s, push_s, pop_req_s, pop_s, under_s;

  // Per-cycle strobes; while flushing every response and pop is swallowed.
  always_comb begin
    flush_s    = !vsync || (state_r == ST_FLUSH);
    accept_s   = mem_req_r && mem_ack;
    last_acc_s = accept_s && (state_r == ST_FETCH) && (mem_addr_r == AW'(FRAME_PIX - 1));
    rsp_s      = mem_rvalid && (outstanding_r != {LW{1'b0}});
    pop_req_s  = read_mem && !flush_s;
    pop_s      = pop_req_s && (level_r != {LW{1'b0}});
    under_s    = pop_req_s && (level_r == {LW{1'b0}});
    push_s     = mem_rvalid && !flush_s && ((level_r != LW'(DEPTH)) || pop_s);
    drop_cnt_s = (state_r == ST_FLUSH) ? outstanding_r : {LW{1'b0}};
  end

  // Next-state logic; vsync low forces FLUSH from any state.
  always_comb begin
    state_s = state_r;
    if (!vsync) begin
      state_s = ST_FLUSH;
    end else begin
      case (state_r)
        ST_FLUSH: if (drop_cnt_s == {LW{1'b0}}) state_s = ST_FETCH; else state_s = ST_FLUSH;
        ST_FETCH: if (last_acc_s) state_s = ST_DONE; else state_s = ST_FETCH;
        ST_DONE:  state_s = ST_DONE;
        default:  state_s = ST_FLUSH;
      endcase
    end
  end

  // Occupancy, in-flight count and the request decision for the next cycle.
  always_comb begin
    outstanding_s = outstanding_r;
    if (accept_s && !rsp_s) begin
      outstanding_s = outstanding_r + LW'(1);
    end else if (!accept_s && rsp_s) begin
      outstanding_s = outstanding_r - LW'(1);
    end else begin
      outstanding_s = outstanding_r;
    end

    level_s = level_r;
    if (flush_s) begin
      level_s = {LW{1'b0}};
    end else if (push_s && !pop_s) begin
      level_s = level_r + LW'(1);
    end else if (!push_s && pop_s) begin
      level_s = level_r - LW'(1);
    end else begin
      level_s = level_r;
    end

    // Slots already promised to in-flight reads count against the FIFO.
    credit_s = {1'b0, level_s} + {1'b0, outstanding_s};

    mem_req_s = 1'b0;
    if (state_s != ST_FETCH) begin
      mem_req_s = 1'b0;
    end else if (mem_req_r && !mem_ack) begin
      mem_req_s = 1'b1;
    end else begin
      mem_req_s = (credit_s < CW'(DEPTH));
    end

    mem_addr_s = mem_addr_r;
    if (flush_s) begin
      mem_addr_s = {AW{1'b0}};
    end else if (accept_s && !last_acc_s) begin
      mem_addr_s = mem_addr_r + AW'(1);
    end else begin
      mem_addr_s = mem_addr_r;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_FLUSH;
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      level_r       <= {LW{1'b0}};
      outstanding_r <= {LW{1'b0}};
      mem_addr_r    <= {AW{1'b0}};
      mem_req_r     <= 1'b0;
      pix_data_r    <= 12'h000;
      underflow_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      level_r       <= level_s;
      outstanding_r <= outstanding_s;
      mem_addr_r    <= mem_addr_s;
      mem_req_r     <= mem_req_s;
      if (flush_s) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (pop_s) begin
        pix_data_r <= fifo_mem_r[rd_ptr_r];
      end else if (under_s) begin
        pix_data_r <= 12'h000;
      end
      if (flush_s) begin
        underflow_r <= 1'b0;
      end else if (under_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only ever read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= mem_rdata;
  end

`ifdef PIX_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_r;

  // Lifetime underflow counter; only rstn clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underflow_cnt_r <= 16'h0000;
    end else if (under_s && (underflow_cnt_r != 16'hFFFF)) begin
      underflow_cnt_r <= underflow_cnt_r + 16'd1;
    end
  end

  assign underflow_cnt = underflow_cnt_r;
`endif

  assign pix_data   = pix_data_r;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign underflow  = underflow_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Self-checking bench for vga_pixel_prefetch: memory responder plus a queue-based pixel model.
// Exercises PIX_UNDERFLOW_CNT_EN when that macro is defined.
module tb_vga_pixel_prefetch;
  localparam int DEPTH     = 16;
  localparam int FRAME_PIX = 1000;
  localparam int AW        = 19;
  localparam int LW        = 5;

  logic          clk, rstn, vsync, read_mem, mem_req, mem_ack, mem_rvalid, underflow;
  logic [11:0]   pix_data, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] fifo_level;
`ifdef PIX_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  vga_pixel_prefetch #(.DEPTH(DEPTH), .FRAME_PIX(FRAME_PIX), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .vsync(vsync), .read_mem(read_mem), .pix_data(pix_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .underflow(underflow), .fifo_level(fifo_level)
`ifdef PIX_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int unsigned due; logic [11:0] data; } resp_t;

  int          n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, last_due = 0, next_addr = 0, ucnt = 0, last_hs_addr = 0;
  int          mdl_out = 0, lat_min = 3, lat_max = 3;
  bit          in_flush = 1'b1, done = 1'b0, prev_pending = 1'b0, exp_under = 1'b0;
  logic [11:0] exp_pix = 12'h000, salt = 12'h000;
  logic [AW-1:0] prev_addr = '0;
  logic [11:0] fifo_q[$];
  resp_t       resp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] data_of(input logic [AW-1:0] a);
    return a[11:0] ^ salt;
  endfunction

  // One clock: memory responds, model advances, outputs are checked at the next negedge.
  task automatic step();
    bit hs, rv, disc, leave;
    int unsigned lat, d;
    if (prev_pending) begin
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, prev_addr);
    end
    rv = 1'b0;
    if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      rv = 1'b1;
      mem_rdata = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      mem_rdata = 12'($urandom);
    end
    mem_rvalid = rv;
    hs = mem_req && mem_ack;
    if (hs) begin
      chk("req_addr", mem_addr, next_addr);
      last_hs_addr = mem_addr;
      lat = $urandom_range(lat_max, lat_min);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      resp_q.push_back('{due: d, data: data_of(mem_addr)});
      if (next_addr == FRAME_PIX - 1) done = 1'b1;
      next_addr++;
    end
    prev_pending = mem_req && !mem_ack && vsync;
    prev_addr = mem_addr;
    disc  = !vsync || in_flush;
    leave = in_flush && vsync && (mdl_out == 0);
    if (disc) begin
      fifo_q.delete();
      exp_under = 1'b0;
    end else begin
      if (read_mem) begin
        if (fifo_q.size() > 0) exp_pix = fifo_q.pop_front();
        else begin
          exp_pix = 12'h000;
          exp_under = 1'b1;
          if (ucnt < 65535) ucnt++;
        end
      end
      if (rv) fifo_q.push_back(mem_rdata);
    end
    mdl_out = mdl_out + int'(hs) - int'(rv);
    if (!vsync) begin
      in_flush = 1'b1; done = 1'b0; next_addr = 0;
    end else if (leave) begin
      in_flush = 1'b0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("pix_data", pix_data, exp_pix);
    chk("underflow", underflow, exp_under);
    chk("fifo_level", fifo_level, fifo_q.size());
    chk("credit", (fifo_level + mdl_out) <= DEPTH, 1);
    if (in_flush) begin
      chk("flush_req", mem_req, 0);
      chk("flush_addr", mem_addr, 0);
    end
    if (done) chk("done_req", mem_req, 0);
`ifdef PIX_UNDERFLOW_CNT_EN
    chk("underflow_cnt", underflow_cnt, ucnt);
`endif
  endtask

  initial begin
    int good;
    rstn = 1'b0; vsync = 1'b0; read_mem = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_pix", pix_data, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_under", underflow, 0);
    chk("rst_level", fifo_level, 0);
    rstn = 1'b1;
    step();

    // Empty pops around a vsync pulse; nothing is acked so the FIFO stays empty.
    vsync = 1'b1; step();
    read_mem = 1'b1; repeat (3) step();
    chk("t6_under_set", underflow, 1);
    read_mem = 1'b0; vsync = 1'b0; step();
    chk("t6_under_clr", underflow, 0);
    vsync = 1'b1; step();
    read_mem = 1'b1; repeat (2) step();
`ifdef PIX_UNDERFLOW_CNT_EN
    chk("t6_cnt5", underflow_cnt, 5);
`endif
    read_mem = 1'b0; vsync = 1'b0; step();

    // Fill: ack every cycle, latency 3, no pops.
    vsync = 1'b1; mem_ack = 1'b1; lat_min = 3; lat_max = 3;
    repeat (30) step();
    chk("t1_level", fifo_level, DEPTH);
    chk("t1_req_low", mem_req, 0);
    chk("t1_addr_cnt", next_addr, DEPTH);

    // Stream 640 pixels.
    read_mem = 1'b1;
    repeat (640) step();
    chk("t2_last_pix", pix_data, 639);
    chk("t2_no_under", underflow, 0);

    // Memory stall while popping.
    mem_ack = 1'b0; good = 0;
    for (int i = 0; i < 40; i++) begin
      if (fifo_q.size() > 0 || (resp_q.size() > 0)) good++;
      step();
    end
    chk("t3_under", underflow, 1);
    chk("t3_pix0", pix_data, 0);
    read_mem = 1'b0; vsync = 1'b0; step();
    chk("t3_under_clr", underflow, 0);

    // Flush with responses in flight.
    salt = 12'h5A3; vsync = 1'b1; mem_ack = 1'b1; lat_min = 8; lat_max = 8;
    for (int i = 0; i < 50 && mdl_out != 5; i++) step();
    chk("t5_inflight", mdl_out, 5);
    vsync = 1'b0; step();
    vsync = 1'b1; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 60 && fifo_q.size() == 0; i++) step();
    chk("t5_level_nz", fifo_level != 0, 1);
    read_mem = 1'b1; step();
    chk("t5_first_pix", pix_data, 12'h5A3);
    read_mem = 1'b0;

    // Random traffic with occasional frame restarts.
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 1500; i++) begin
      mem_ack  = ($urandom_range(3, 0) != 0);
      read_mem = $urandom_range(1, 0) == 1;
      vsync    = ($urandom_range(199, 0) != 0);
      step();
    end

    // Full frame.
    vsync = 1'b0; read_mem = 1'b0; step();
    vsync = 1'b1; mem_ack = 1'b1; read_mem = 1'b1; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 5000 && !done; i++) step();
    chk("t4_done", done, 1);
    chk("t4_last_addr", last_hs_addr, FRAME_PIX - 1);
    repeat (30) step();
    chk("t4_req_low", mem_req, 0);
    vsync = 1'b0; step();
    vsync = 1'b1; read_mem = 1'b0;
    repeat (6) step();
    chk("t4_restart", next_addr > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
